// File: rtl/cdb_pkg.sv
// Shared definitions for the Common Data Bus producer.
//   cdb_pkt_t  : one broadcast result {data, prf_idx, rob_idx}; validity travels
//                separately so that an empty slot is just an all-zero packet.
//   XLEN/PRF/ROB and the derived index widths size every port of the block.
//   wrap_idx() : single-step modulo used by the rotating-priority scan.
package cdb_pkg;

  localparam int XLEN      = 32;
  localparam int PRF       = 64;
  localparam int ROB       = 16;
  localparam int PRF_IDX_W = $clog2(PRF);
  localparam int ROB_IDX_W = $clog2(ROB);

  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [PRF_IDX_W-1:0] prf_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_pkt_t;

  localparam int PKT_W = $bits(cdb_pkt_t);

  // i is known to be below 2*n, so one conditional subtract is a full modulo.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? (i - n) : i;
  endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU result buffer in front of the CDB arbiter.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-low reset
//   push          : write din at this edge (ignored when full)
//   pop           : retire the head at this edge (ignored when empty)
//   flush         : empty the buffer; wins over push and pop
//   din / dout    : write data / current head (stale when empty)
//   empty, count  : occupancy, registered
module cdb_fu_fifo
  import cdb_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  cdb_pkt_t      din,
  output cdb_pkt_t      dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  localparam int PW = $clog2(DEPTH);

  cdb_pkt_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: an entry is only read after count says it was written.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Producer end of the Common Data Bus.
// Collects results from NUM_FU functional units into per-FU FIFOs and
// broadcasts up to WAYS of them per cycle on registered CDB slots, using a
// rotating (round-robin) priority between FUs.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   squash              : synchronous flush of all buffered results and the bus
//   fu_valid/fu_ready   : per-FU result handshake
//   fu_data/prf/rob_idx : result payload of each FU
//   CDB_Data/PRF/rob    : registered broadcast payload, one per slot
//   CDB_valid           : slot carries a result this cycle
//
// Handshake: a result transfers at a rising edge where fu_valid[i] and
// fu_ready[i] are both high. fu_ready[i] depends only on registered
// occupancy, so a producer may look at it without any combinational loop
// through fu_valid; a pop at the same edge does not raise it. A producer that
// is not accepted must hold its valid and payload until it is.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU    = 6,
  parameter int WAYS      = 3,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_data,
  input  logic [NUM_FU-1:0][PRF_IDX_W-1:0]     fu_prf_idx,
  input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_idx,
  output logic [NUM_FU-1:0]                    fu_ready,
  output logic [WAYS-1:0][XLEN-1:0]            CDB_Data,
  output logic [WAYS-1:0][PRF_IDX_W-1:0]       CDB_PRF_idx,
  output logic [WAYS-1:0][ROB_IDX_W-1:0]       CDB_rob_idx,
  output logic [WAYS-1:0]                      CDB_valid
);

  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [FU_W-1:0]   rr_ptr;
  logic [FU_W-1:0]   rr_next;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] empty;
  cdb_pkt_t          in_pkt [NUM_FU];
  cdb_pkt_t          head   [NUM_FU];
  logic [CNT_W-1:0]  count  [NUM_FU];
  cdb_pkt_t          slot_pkt [WAYS];
  logic [WAYS-1:0]   slot_vld;
  cdb_pkt_t          cdb_q    [WAYS];

  // ---------------------------------------------------------------------------
  // Per-FU buffers. A granted head pops at the same edge the CDB registers
  // capture it; squash drives flush, which overrides both push and pop.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
    assign push[i]     = fu_valid[i] & fu_ready[i];
    assign in_pkt[i]   = {fu_data[i], fu_prf_idx[i], fu_rob_idx[i]};

    cdb_fu_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[i]),
      .pop   (grant[i]),
      .flush (squash),
      .din   (in_pkt[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Rotating-priority selector and slot packer. The scan starts at rr_ptr and
  // wraps; the first WAYS non-empty FIFOs win and fill slots 0.. in scan order.
  // Only registered occupancy is looked at, so a push this cycle is invisible
  // here until the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    int g;
    int idx;
    int last;
    g        = 0;
    idx      = 0;
    last     = 0;
    grant    = '0;
    slot_vld = '0;
    for (int s = 0; s < WAYS; s++) slot_pkt[s] = '0;

    for (int k = 0; k < NUM_FU; k++) begin
      idx = wrap_idx(int'(rr_ptr) + k, NUM_FU);
      if (!empty[idx] && (g < WAYS)) begin
        grant[idx]  = 1'b1;
        slot_pkt[g] = head[idx];
        slot_vld[g] = 1'b1;
        g           = g + 1;
        last        = idx;
      end
    end

    // Priority moves just past the last winner; an idle cycle keeps it.
    rr_next = rr_ptr;
    if (g > 0) rr_next = FU_W'(wrap_idx(last + 1, NUM_FU));
  end

  // ---------------------------------------------------------------------------
  // Registered broadcast. Unused slots are loaded with zero payload so the bus
  // never shows stale data next to a low valid bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      CDB_valid <= '0;
      for (int s = 0; s < WAYS; s++) cdb_q[s] <= '0;
    end else if (squash) begin
      rr_ptr    <= '0;
      CDB_valid <= '0;
      for (int s = 0; s < WAYS; s++) cdb_q[s] <= '0;
    end else begin
      rr_ptr    <= rr_next;
      CDB_valid <= slot_vld;
      for (int s = 0; s < WAYS; s++) cdb_q[s] <= slot_pkt[s];
    end
  end

  for (genvar s = 0; s < WAYS; s++) begin : g_slot
    assign CDB_Data[s]    = cdb_q[s].data;
    assign CDB_PRF_idx[s] = cdb_q[s].prf_idx;
    assign CDB_rob_idx[s] = cdb_q[s].rob_idx;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter. Two instances share one set of FU inputs: the default
// WAYS=3 build and a WAYS=1 build. A queue-based model (one result queue per
// FU per instance plus a rotating start index) predicts fu_ready and every CDB
// slot each cycle. Producers obey the valid/ready handshake as seen by the
// WAYS=3 instance; the WAYS=1 instance simply accepts whatever its own ready
// allows, which the model tracks independently.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NUM_FU = 6;
  localparam int WAYS   = 3;
  localparam int BD     = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic squash = 1'b0;
  always #5 clock = ~clock;

  logic [NUM_FU-1:0]                fu_valid = '0;
  logic [NUM_FU-1:0][XLEN-1:0]      fu_data = '0;
  logic [NUM_FU-1:0][PRF_IDX_W-1:0] fu_prf_idx = '0;
  logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx = '0;

  logic [NUM_FU-1:0]              fu_ready_a;
  logic [WAYS-1:0][XLEN-1:0]      cdb_data_a;
  logic [WAYS-1:0][PRF_IDX_W-1:0] cdb_prf_a;
  logic [WAYS-1:0][ROB_IDX_W-1:0] cdb_rob_a;
  logic [WAYS-1:0]                cdb_valid_a;

  logic [NUM_FU-1:0]           fu_ready_b;
  logic [0:0][XLEN-1:0]        cdb_data_b;
  logic [0:0][PRF_IDX_W-1:0]   cdb_prf_b;
  logic [0:0][ROB_IDX_W-1:0]   cdb_rob_b;
  logic [0:0]                  cdb_valid_b;

  cdb_arbiter #(.NUM_FU(NUM_FU), .WAYS(WAYS), .BUF_DEPTH(BD)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_data(fu_data), .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready_a), .CDB_Data(cdb_data_a), .CDB_PRF_idx(cdb_prf_a),
    .CDB_rob_idx(cdb_rob_a), .CDB_valid(cdb_valid_a)
  );

  cdb_arbiter #(.NUM_FU(NUM_FU), .WAYS(1), .BUF_DEPTH(BD)) dut_w1 (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_data(fu_data), .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready_b), .CDB_Data(cdb_data_b), .CDB_PRF_idx(cdb_prf_b),
    .CDB_rob_idx(cdb_rob_b), .CDB_valid(cdb_valid_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  // Model: exp_q[m*NUM_FU + f] holds FU f's buffered results for instance m.
  logic [PKT_W-1:0] exp_q [2*NUM_FU][$];
  int               m_rr    [2];
  logic [WAYS-1:0]  exp_vld [2];
  logic [PKT_W-1:0] exp_slot [2][WAYS];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int q = 0; q < 2*NUM_FU; q++) exp_q[q].delete();
    for (int m = 0; m < 2; m++) begin
      m_rr[m]    = 0;
      exp_vld[m] = '0;
      for (int s = 0; s < WAYS; s++) exp_slot[m][s] = '0;
    end
  endtask

  // One clock edge of the bus for instance m with `ways` slots.
  task automatic model_edge(input int m, input int ways);
    logic [NUM_FU-1:0] acc;
    int g;
    int last;
    int f;
    for (int i = 0; i < NUM_FU; i++)
      acc[i] = fu_valid[i] && (exp_q[m*NUM_FU+i].size() < BD);
    exp_vld[m] = '0;
    for (int s = 0; s < WAYS; s++) exp_slot[m][s] = '0;
    if (squash) begin
      for (int i = 0; i < NUM_FU; i++) exp_q[m*NUM_FU+i].delete();
      m_rr[m] = 0;
      return;
    end
    g = 0;
    last = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      f = (m_rr[m] + k) % NUM_FU;
      if (g < ways && exp_q[m*NUM_FU+f].size() > 0) begin
        exp_slot[m][g] = exp_q[m*NUM_FU+f].pop_front();
        exp_vld[m][g]  = 1'b1;
        g++;
        last = f;
      end
    end
    if (g > 0) m_rr[m] = (last + 1) % NUM_FU;
    for (int i = 0; i < NUM_FU; i++)
      if (acc[i]) exp_q[m*NUM_FU+i].push_back({fu_data[i], fu_prf_idx[i], fu_rob_idx[i]});
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic load_fu(input int i, input logic [XLEN-1:0] d,
                         input logic [PRF_IDX_W-1:0] p, input logic [ROB_IDX_W-1:0] r);
    fu_valid[i]   = 1'b1;
    fu_data[i]    = d;
    fu_prf_idx[i] = p;
    fu_rob_idx[i] = r;
  endtask

  // Called between edges with inputs set: checks ready, advances one edge,
  // checks the bus, then retires accepted producer items.
  task automatic tick();
    logic [NUM_FU-1:0] rdy_a;
    logic [NUM_FU-1:0] rdy_b;
    logic [NUM_FU-1:0] acc;
    for (int i = 0; i < NUM_FU; i++) begin
      rdy_a[i] = exp_q[i].size() < BD;
      rdy_b[i] = exp_q[NUM_FU+i].size() < BD;
    end
    check_eq("ready_a", 64'(fu_ready_a), 64'(rdy_a));
    check_eq("ready_b", 64'(fu_ready_b), 64'(rdy_b));
    acc = fu_valid & rdy_a;
    model_edge(0, WAYS);
    model_edge(1, 1);
    @(posedge clock);
    #1;
    check_eq("valid_a", 64'(cdb_valid_a), 64'(exp_vld[0]));
    for (int s = 0; s < WAYS; s++)
      check_eq($sformatf("slot_a%0d", s), 64'({cdb_data_a[s], cdb_prf_a[s], cdb_rob_a[s]}),
               64'(exp_slot[0][s]));
    check_eq("valid_b", 64'(cdb_valid_b), 64'(exp_vld[1][0]));
    check_eq("slot_b0", 64'({cdb_data_b[0], cdb_prf_b[0], cdb_rob_b[0]}), 64'(exp_slot[1][0]));
    for (int i = 0; i < NUM_FU; i++)
      if (acc[i]) fu_valid[i] = 1'b0;
  endtask

  task automatic squash_tick();
    squash = 1'b1;
    tick();
    squash = 1'b0;
  endtask

  // Asynchronous reset between edges, held across one edge with garbage on
  // the FU inputs, released between edges.
  task automatic async_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_valid_a", 64'(cdb_valid_a), 64'(0));
    check_eq("rst_valid_b", 64'(cdb_valid_b), 64'(0));
    check_eq("rst_ready_a", 64'(fu_ready_a), 64'(6'h3f));
    fu_valid = '1;
    @(posedge clock);
    #1;
    check_eq("rst_hold_valid", 64'(cdb_valid_a), 64'(0));
    check_eq("rst_hold_ready", 64'(fu_ready_a), 64'(6'h3f));
    @(negedge clock);
    reset    = 1'b1;
    fu_valid = '0;
    model_clear();
  endtask

  // ---------------------------------------------------------------- sequence
  logic [PRF_IDX_W-1:0] bp_seen[$];
  int                   bp_next;
  int                   fair_cnt;
  logic [ROB_IDX_W-1:0] fair_exp;

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset_valid", 64'(cdb_valid_a), 64'(0));
    check_eq("reset_slots", 64'({cdb_data_a, cdb_prf_a, cdb_rob_a}), 64'(0));
    check_eq("reset_ready", 64'(fu_ready_a), 64'(6'h3f));
    reset = 1'b1;

    // Contention from rr=0: all six FUs push at the same edge.
    for (int i = 0; i < NUM_FU; i++)
      load_fu(i, 32'hC000_0000 + i, PRF_IDX_W'(20 + i), ROB_IDX_W'(i));
    tick();
    tick();
    check_eq("cont_v1", 64'(cdb_valid_a), 64'(3'b111));
    check_eq("cont_1", 64'({cdb_rob_a[2], cdb_rob_a[1], cdb_rob_a[0]}), 64'({4'd2, 4'd1, 4'd0}));
    tick();
    check_eq("cont_v2", 64'(cdb_valid_a), 64'(3'b111));
    check_eq("cont_2", 64'({cdb_rob_a[2], cdb_rob_a[1], cdb_rob_a[0]}), 64'({4'd5, 4'd4, 4'd3}));

    // Single result, two-edge latency.
    load_fu(2, 32'hDEAD_BEEF, PRF_IDX_W'(17), ROB_IDX_W'(5));
    tick();
    check_eq("single_lat1", 64'(cdb_valid_a), 64'(0));
    tick();
    check_eq("single_valid", 64'(cdb_valid_a), 64'(3'b001));
    check_eq("single_data", 64'(cdb_data_a[0]), 64'(32'hDEAD_BEEF));
    check_eq("single_prf", 64'(cdb_prf_a[0]), 64'(17));
    check_eq("single_rob", 64'(cdb_rob_a[0]), 64'(5));

    // Fairness on the single-slot bus: FU0 and FU1 always offering.
    squash_tick();
    fair_cnt = 0;
    fair_exp = '0;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 2; i++)
        if (!fu_valid[i]) load_fu(i, $urandom, PRF_IDX_W'($urandom_range(0, 63)), ROB_IDX_W'(i));
      tick();
      if (cdb_valid_b[0]) begin
        check_eq("fair_order", 64'(cdb_rob_b[0]), 64'(fair_exp));
        fair_exp = fair_exp ^ ROB_IDX_W'(1);
        fair_cnt++;
      end
    end
    check_eq("fair_grants", 64'(fair_cnt), 64'(11));
    squash_tick();

    // Backpressure: FU3 offers three results behind FU0..FU2 traffic.
    bp_next = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n <= 4)
        for (int i = 0; i < 3; i++)
          if (!fu_valid[i]) load_fu(i, $urandom, PRF_IDX_W'($urandom_range(0, 40)), ROB_IDX_W'(i));
      if (!fu_valid[3] && bp_next < 3) begin
        load_fu(3, 32'hB000_0000 + bp_next, PRF_IDX_W'(60 + bp_next), ROB_IDX_W'(3));
        bp_next++;
      end
      tick();
      for (int s = 0; s < WAYS; s++)
        if (cdb_valid_a[s] && cdb_rob_a[s] == 3) bp_seen.push_back(cdb_prf_a[s]);
      if (n == 2) check_eq("bp_ready3", 64'(fu_ready_a[3]), 64'(0));
    end
    check_eq("bp_count", 64'(bp_seen.size()), 64'(3));
    for (int k = 0; k < 3 && k < bp_seen.size(); k++)
      check_eq($sformatf("bp_order%0d", k), 64'(bp_seen[k]), 64'(60 + k));

    // Squash with four results buffered and FU1 pushing at the squash edge.
    for (int i = 0; i < 4; i++)
      load_fu(i, 32'h5000_0000 + i, PRF_IDX_W'(i), ROB_IDX_W'(i));
    tick();
    load_fu(1, 32'h5111_1111, PRF_IDX_W'(33), ROB_IDX_W'(9));
    squash_tick();
    check_eq("sq_valid", 64'(cdb_valid_a), 64'(0));
    check_eq("sq_ready_a", 64'(fu_ready_a), 64'(6'h3f));
    check_eq("sq_ready_b", 64'(fu_ready_b), 64'(6'h3f));
    tick();
    check_eq("sq_dropped", 64'(cdb_valid_a), 64'(0));
    load_fu(5, 32'h0000_0055, PRF_IDX_W'(5), ROB_IDX_W'(5));
    load_fu(0, 32'h0000_0011, PRF_IDX_W'(1), ROB_IDX_W'(0));
    tick();
    tick();
    check_eq("sq_rr_valid", 64'(cdb_valid_a), 64'(3'b011));
    check_eq("sq_rr_order", 64'({cdb_rob_a[1], cdb_rob_a[0]}), 64'({4'd5, 4'd0}));

    // Randomized traffic with occasional squash.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_FU; i++)
        if (!fu_valid[i] && $urandom_range(0, 99) < 60)
          load_fu(i, $urandom, PRF_IDX_W'($urandom_range(0, 63)), ROB_IDX_W'($urandom_range(0, 15)));
      squash = ($urandom_range(0, 39) == 0);
      tick();
      squash = 1'b0;
    end

    // Asynchronous reset in the middle of a burst, then a fresh result.
    for (int i = 0; i < NUM_FU; i++)
      if (!fu_valid[i]) load_fu(i, $urandom, PRF_IDX_W'(i), ROB_IDX_W'(i));
    tick();
    async_reset();
    load_fu(4, 32'h1234_5678, PRF_IDX_W'(9), ROB_IDX_W'(7));
    tick();
    check_eq("post_rst_lat1", 64'(cdb_valid_a), 64'(0));
    tick();
    check_eq("post_rst_valid", 64'(cdb_valid_a), 64'(3'b001));
    check_eq("post_rst_data", 64'(cdb_data_a[0]), 64'(32'h1234_5678));
    check_eq("post_rst_rob", 64'(cdb_rob_a[0]), 64'(7));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
